// File: rtl/video_timing_pkg.sv
// Default raster timing constants and helpers shared by the timing generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package video_timing_pkg;

  // One axis of a raster: visible span, then front porch, sync, back porch.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  // 1600x900 reduced-blanking set.
  localparam timing_t H_DEFAULT = '{active: 1600, fp: 24, sync: 80, bp: 96};
  localparam timing_t V_DEFAULT = '{active: 900,  fp: 1,  sync: 3,  bp: 96};

  // Full axis length, blanking included.
  function automatic int total(input timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Every region must be at least one unit wide.
  function automatic bit legal(input timing_t t);
    return (t.active >= 1) && (t.fp >= 1) && (t.sync >= 1) && (t.bp >= 1);
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis counter (0..total-1) with region flags decoded from the count.
// Latency: flags are combinational from the count; count advances one per step.
// Backpressure: none; the counter holds whenever step is low.
// Ports: clk, rst (sync, active-high), step (advance enable),
//        cnt (position), last (cnt==total-1), active (visible span), sync (sync window).
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter timing_t T     = H_DEFAULT,
  localparam int     TOTAL = total(T),
  localparam int     W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST_C    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_C  = W'(T.active);
  localparam logic [W-1:0] SYNC_LO_C = W'(T.active + T.fp);
  localparam logic [W-1:0] SYNC_HI_C = W'(T.active + T.fp + T.sync);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign last   = (cnt == LAST_C);
  assign active = (cnt < ACTIVE_C);
  // Sync window ends before the back porch, so SYNC_HI_C always fits in W bits.
  assign sync   = (cnt >= SYNC_LO_C) && (cnt < SYNC_HI_C);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: walks H/V counters over the full frame and emits registered
// dv/line_end/frame_start/sync/coordinate signals. Latency: outputs show the position of
// the previous enabled cycle. Backpressure: ce=0 holds position and blanks the pulses.
// Ports: clk, rst (sync, active-high), ce (pixel enable); dv_o, line_end_o, frame_start_o,
//        hs_o, vs_o, x_o, y_o.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int  H_ACTIVE = H_DEFAULT.active,
  parameter int  H_FP     = H_DEFAULT.fp,
  parameter int  H_SYNC   = H_DEFAULT.sync,
  parameter int  H_BP     = H_DEFAULT.bp,
  parameter int  V_ACTIVE = V_DEFAULT.active,
  parameter int  V_FP     = V_DEFAULT.fp,
  parameter int  V_SYNC   = V_DEFAULT.sync,
  parameter int  V_BP     = V_DEFAULT.bp,
  parameter bit  HS_POL   = 1'b1,
  parameter bit  VS_POL   = 1'b1,
  localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
  localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
  localparam int  H_TOTAL = total(H_T),
  localparam int  V_TOTAL = total(V_T),
  localparam int  XW      = $clog2(H_TOTAL),
  localparam int  YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          dv_o,
  output logic          line_end_o,
  output logic          frame_start_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  if (!legal(H_T) || !legal(V_T)) begin : g_bad_timing
    $error("video_timing_gen: every active, porch and sync width must be >= 1");
  end

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_last;
  logic          h_active;
  logic          h_sync;
  logic          v_last;
  logic          v_active;
  logic          v_sync;

  timing_axis_counter #(.T(H_T)) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (ce),
    .cnt    (h_cnt),
    .last   (h_last),
    .active (h_active),
    .sync   (h_sync)
  );

  // V advances on the enabled cycle that closes a line, so vs only moves at h_cnt=0.
  timing_axis_counter #(.T(V_T)) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (h_last & ce),
    .cnt    (v_cnt),
    .last   (v_last),
    .active (v_active),
    .sync   (v_sync)
  );

  // v_last is not needed here: the H counter wrap plus V counter wrap close the frame.
  logic unused_v_last;
  assign unused_v_last = v_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_o          <= 1'b0;
      line_end_o    <= 1'b0;
      frame_start_o <= 1'b0;
      hs_o          <= ~HS_POL;
      vs_o          <= ~VS_POL;
      x_o           <= '0;
      y_o           <= '0;
    end else if (ce) begin
      dv_o          <= h_active & v_active;
      line_end_o    <= h_last;
      frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
      hs_o          <= h_sync ? HS_POL : ~HS_POL;
      vs_o          <= v_sync ? VS_POL : ~VS_POL;
      x_o           <= h_cnt;
      y_o           <= v_cnt;
    end else begin
      // Pulses are qualified by ce so a stalled position is never reported twice;
      // levels and coordinates keep their last value.
      dv_o          <= 1'b0;
      line_end_o    <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  // Instance 0: H=4/1/1/1 (7), V=2/1/1/1 (5), positive syncs.
  logic       dv0, le0, fs0, hs0, vs0;
  logic [2:0] x0;
  logic [2:0] y0;
  // Instance 1: H=5/2/3/2 (12), V=3/1/2/1 (7), negative syncs.
  logic       dv1, le1, fs1, hs1, vs1;
  logic [3:0] x1;
  logic [2:0] y1;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .ce(ce),
    .dv_o(dv0), .line_end_o(le0), .frame_start_o(fs0),
    .hs_o(hs0), .vs_o(vs0), .x_o(x0), .y_o(y0)
  );

  video_timing_gen #(
    .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .ce(ce),
    .dv_o(dv1), .line_end_o(le1), .frame_start_o(fs1),
    .hs_o(hs1), .vs_o(vs1), .x_o(x1), .y_o(y1)
  );

  localparam int HA[2] = '{4, 5};
  localparam int HF[2] = '{1, 2};
  localparam int HS[2] = '{1, 3};
  localparam int HB[2] = '{1, 2};
  localparam int VA[2] = '{2, 3};
  localparam int VF[2] = '{1, 1};
  localparam int VS[2] = '{1, 2};
  localparam int VB[2] = '{1, 1};
  localparam int HP[2] = '{1, 0};
  localparam int VP[2] = '{1, 0};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: linear pixel index within the frame, split into (x,y) arithmetically.
  int pos  [2];
  int e_dv [2];
  int e_le [2];
  int e_fs [2];
  int e_hs [2];
  int e_vs [2];
  int e_x  [2];
  int e_y  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic c);
    for (int i = 0; i < 2; i++) begin
      int ht, vt, h, v;
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      if (r) begin
        pos[i]  = 0;
        e_dv[i] = 0; e_le[i] = 0; e_fs[i] = 0;
        e_hs[i] = 1 - HP[i];
        e_vs[i] = 1 - VP[i];
        e_x[i]  = 0; e_y[i] = 0;
      end else if (c) begin
        h = pos[i] % ht;
        v = pos[i] / ht;
        e_dv[i] = (h < HA[i] && v < VA[i]) ? 1 : 0;
        e_le[i] = (h == ht - 1) ? 1 : 0;
        e_fs[i] = (pos[i] == 0) ? 1 : 0;
        e_hs[i] = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : 1 - HP[i];
        e_vs[i] = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : 1 - VP[i];
        e_x[i]  = h;
        e_y[i]  = v;
        pos[i]  = (pos[i] + 1) % (ht * vt);
      end else begin
        e_dv[i] = 0; e_le[i] = 0; e_fs[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("d0.dv", dv0, e_dv[0]);
    check("d0.line_end", le0, e_le[0]);
    check("d0.frame_start", fs0, e_fs[0]);
    check("d0.hs", hs0, e_hs[0]);
    check("d0.vs", vs0, e_vs[0]);
    check("d0.x", x0, e_x[0]);
    check("d0.y", y0, e_y[0]);
    check("d1.dv", dv1, e_dv[1]);
    check("d1.line_end", le1, e_le[1]);
    check("d1.frame_start", fs1, e_fs[1]);
    check("d1.hs", hs1, e_hs[1]);
    check("d1.vs", vs1, e_vs[1]);
    check("d1.x", x1, e_x[1]);
    check("d1.y", y1, e_y[1]);
  endtask

  // Drive inputs, take one clock edge, update the reference, then sample 1 time unit later.
  task automatic step(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    compare_all();
  endtask

  initial begin
    int cnt_dv, cnt_le, second_fs, found;
    rst = 1'b1;
    ce  = 1'b0;

    // Reset, including rst and ce high together.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rst_dv", dv0, 0);
    check("rst_hs_neg", hs1, 1);
    check("rst_vs_neg", vs1, 1);

    // Release with ce high: first edge is pixel (0,0).
    step(1'b0, 1'b1);
    check("first_fs", fs0, 1);
    check("first_dv", dv0, 1);
    check("first_x", x0, 0);
    check("first_y", y0, 0);
    cnt_dv    = int'(dv0);
    cnt_le    = int'(le0);
    second_fs = -1;
    for (int i = 1; i < 70; i++) begin
      step(1'b0, 1'b1);
      if (i < 35) begin
        cnt_dv += int'(dv0);
        cnt_le += int'(le0);
      end
      if (fs0 && second_fs < 0) second_fs = i;
    end
    check("frame_dv_count", cnt_dv, 8);
    check("frame_line_end_count", cnt_le, 5);
    check("frame_period", second_fs, 35);

    // Mid-frame reset at (2,1), then restart at (0,0).
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(1'b0, 1'b1);
      if (x0 == 3'd2 && y0 == 3'd1) found = 1;
    end
    check("midrst_reached", found, 1);
    step(1'b1, 1'b1);
    check("midrst_x", x0, 0);
    check("midrst_y", y0, 0);
    step(1'b0, 1'b1);
    check("restart_fs", fs0, 1);

    // ce at 1/3 duty with rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0));
    end

    // Mostly-enabled ce with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing source for the pixel pipeline. Walks a horizontal and a vertical counter over the full frame, blanking included. Emits registered data-valid, line-end, sync and coordinate signals that drive the line buffers and downstream window stages. This is the transmitter of the `dv`/`line_end` stream that the line buffers consume. Its `line_end` pulse resets a line buffer's column address so that the next cycle addresses column 0.

## Interface
- `H_ACTIVE`, 1600, visible pixels per line
- `H_FP`, 24, horizontal front porch (cycles)
- `H_SYNC`, 80, horizontal sync width
- `H_BP`, 96, horizontal back porch; `H_TOTAL` = sum = 1800
- `V_ACTIVE`, 900, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vertical sync width
- `V_BP`, 96, vertical back porch; `V_TOTAL` = sum = 1000
- `HS_POL`, 1, active level of `hs_o`
- `VS_POL`, 1, active level of `vs_o`
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `ce`  in  1  pixel clock enable; counters advance only when high
- `dv_o`  out  1  pixel in active area
- `line_end_o`  out  1  one-cycle pulse on last cycle of every line (active and blanking)
- `frame_start_o`  out  1  one-cycle pulse on pixel (0,0)
- `hs_o`  out  1  horizontal sync
- `vs_o`  out  1  vertical sync
- `x_o`  out  $clog2(H_TOTAL)  current horizontal position
- `y_o`  out  $clog2(V_TOTAL)  current vertical position

## Operation
- Internal counters are `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1). Both reset to 0.
- On an enabled edge (`ce=1`):
  - Outputs register a decode of the current (`h_cnt`,`v_cnt`).
  - Then `h_cnt` increments.
  - At `h_cnt=H_TOTAL-1`, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `v_cnt=V_TOTAL-1` with `h_cnt=H_TOTAL-1`, both wrap to 0.
- Decode of `dv`: `h_cnt<H_ACTIVE` and `v_cnt<V_ACTIVE`.
- Decode of `line_end`: `h_cnt==H_TOTAL-1`.
- Decode of `frame_start`: `h_cnt==0` and `v_cnt==0`.
- Decode of `hs`: `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) → `HS_POL`, else `~HS_POL`.
- Decode of `vs`: same rule on `v_cnt` with the V parameters and `VS_POL`. `vs` changes only at line boundaries, aligned with `h_cnt=0`.
- Decode of `x`/`y`: `h_cnt`/`v_cnt`.
- Cycle with `ce=0`:
  - Counters hold.
  - `dv_o`, `line_end_o` and `frame_start_o` are forced 0 on the next edge.
  - `hs_o`, `vs_o`, `x_o` and `y_o` hold.
  - Pulses are never duplicated across stalls.
- Reset values: `dv_o=0`, `line_end_o=0`, `frame_start_o=0`, `hs_o=~HS_POL`, `vs_o=~VS_POL`, `x_o=0`, `y_o=0`.
- Reset mid-frame takes effect on that edge. The next enabled edge restarts at (0,0) with `frame_start_o`.
- Parameter legality is checked at elaboration:
  - Every porch and sync width must be ≥1.
  - `H_ACTIVE` ≥ 1 and `V_ACTIVE` ≥ 1.
  - A violation is an elaboration error.

## Timing
- Latency: outputs reflect counter state one enabled cycle earlier. The first enabled edge after `rst` falls gives `frame_start_o=1`, `dv_o=1`, `x_o=0`, `y_o=0`.
- `line_end_o` is high exactly 1 cycle per line, coincident with `x_o=H_TOTAL-1`. The cycle after it shows `x_o=0`.
- `dv_o` is high for `H_ACTIVE` consecutive enabled cycles per active line. It is low for all `V_TOTAL-V_ACTIVE` blanking lines.
- Frame period with `ce` tied high: `H_TOTAL*V_TOTAL` = 1,800,000 cycles.
- Boundary cases:
  - On the last cycle of a frame, `line_end_o` is high in the cycle before `frame_start_o`.
  - `rst` and `ce` high together: reset wins.

## Structure
- Package `video_timing_pkg` holds the default timing constants (1600x900 reduced-blanking set) and a `timing_t` struct with fields `active`, `fp`, `sync`, `bp`.
- The package also provides a `total()` function used to derive `H_TOTAL`/`V_TOTAL` and the counter widths.
- One sub-module, `timing_axis_counter`, is instantiated twice (H and V).
  - Inputs: step enable. Outputs: count, `last`, `active`, `sync` flags.
  - The V instance is stepped by the H instance's `last` AND `ce`.
- The top level handles output registration, polarity and `ce` gating.

## Test plan
- Release `rst` with `ce=1` → first edge gives `frame_start_o=1`, `dv_o=1`, `x_o=0`, `y_o=0`. Total `dv_o` count per frame = 1,440,000. `frame_start_o` recurs after exactly 1,800,000 cycles.
- Line check → `line_end_o` pulses when `x_o=1799` every line. The `hs_o` active window is `x_o` 1624..1703 (80 cycles). `dv_o` falls after `x_o=1599`.
- Frame check → `vs_o` is active for `y_o` 901..903. `dv_o` is never high for `y_o`≥900. 1000 `line_end_o` pulses per frame.
- `ce` toggled at 1/3 duty (pseudo-random stalls) → same pulse counts per frame as above, no pulse duplicated during a stall, `x_o` holds during `ce=0`.
- `rst` asserted for 1 cycle at `x_o=500`, `y_o=300` → all outputs at reset values next cycle, then restart at (0,0) with `frame_start_o`.
- Small parameter set H=4/1/1/1, V=2/1/1/1 → exhaustive waveform compare against the golden sequence. `line_end_o` every 7 cycles, frame every 35 cycles.
